// File: rtl/codec_i2c_config.sv
// Power-up configuration sequencer for the audio codec.
// Sends each 16-bit ROM word as one I2C write through i2c_master, retrying an entry a bounded number of times when it is NACKed.
module codec_i2c_config #(
    parameter logic [15:0] POWERUP_DELAY = 16'd50000,
    parameter logic [3:0]  NUM_REGS      = 4'd10,
    parameter logic [7:0]  DEVICE_ADDR   = 8'h34,
    parameter logic [1:0]  MAX_RETRY     = 2'd3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cfg_start,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_fail,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        i2c_start_transaction,
    output logic        i2c_end_transaction,
    output logic        i2c_start_write,
    output logic        i2c_start_read,
    output logic [7:0]  i2c_data_out,
    input  logic        i2c_ready,
    input  logic        i2c_error,
    input  logic        i2c_busy
);

    typedef enum logic [2:0] {
        ST_DELAY, ST_START, ST_ADDR, ST_HI, ST_LO, ST_STOP, ST_DONE, ST_FAIL
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE, PH_GAP, PH_WAIT
    } phase_t;

    state_t      state;
    phase_t      phase;
    logic [15:0] delay_cnt;
    logic [1:0]  retry_cnt;
    logic        abort;

    logic [16:0] delay_next;
    logic [2:0]  retry_next;

    assign delay_next     = {1'b0, delay_cnt} + 17'd1;
    assign retry_next     = {1'b0, retry_cnt} + 3'd1;
    assign i2c_start_read = 1'b0;

    // Every command state runs ISSUE -> GAP -> WAIT; the GAP cycle hides the stale ready the master still shows right after a strobe.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state                 <= ST_DELAY;
            phase                 <= PH_ISSUE;
            delay_cnt             <= '0;
            retry_cnt             <= '0;
            abort                 <= 1'b0;
            rom_addr              <= '0;
            cfg_busy              <= 1'b0;
            cfg_done              <= 1'b0;
            cfg_fail              <= 1'b0;
            i2c_start_transaction <= 1'b0;
            i2c_end_transaction   <= 1'b0;
            i2c_start_write       <= 1'b0;
            i2c_data_out          <= '0;
        end else begin
            i2c_start_transaction <= 1'b0;
            i2c_end_transaction   <= 1'b0;
            i2c_start_write       <= 1'b0;

            case (state)
                ST_DELAY: begin
                    cfg_busy <= 1'b1;
                    if (delay_next >= {1'b0, POWERUP_DELAY}) begin
                        state     <= ST_START;
                        phase     <= PH_ISSUE;
                        delay_cnt <= '0;
                    end else begin
                        delay_cnt <= delay_next[15:0];
                    end
                end

                ST_DONE, ST_FAIL: begin
                    if (cfg_start) begin
                        cfg_done  <= 1'b0;
                        cfg_fail  <= 1'b0;
                        cfg_busy  <= 1'b1;
                        rom_addr  <= '0;
                        retry_cnt <= '0;
                        abort     <= 1'b0;
                        state     <= ST_START;
                        phase     <= PH_ISSUE;
                    end
                end

                default: begin
                    case (phase)
                        PH_ISSUE: begin
                            if (i2c_ready && !i2c_busy) begin
                                phase <= PH_GAP;
                                case (state)
                                    ST_START: i2c_start_transaction <= 1'b1;
                                    ST_ADDR: begin
                                        i2c_start_write <= 1'b1;
                                        i2c_data_out    <= DEVICE_ADDR;
                                    end
                                    ST_HI: begin
                                        i2c_start_write <= 1'b1;
                                        i2c_data_out    <= rom_data[15:8];
                                    end
                                    ST_LO: begin
                                        i2c_start_write <= 1'b1;
                                        i2c_data_out    <= rom_data[7:0];
                                    end
                                    default: i2c_end_transaction <= 1'b1;
                                endcase
                            end
                        end

                        PH_GAP: phase <= PH_WAIT;

                        default: begin
                            if (i2c_ready) begin
                                phase <= PH_ISSUE;
                                if ((state == ST_ADDR || state == ST_HI || state == ST_LO) && i2c_error)
                                    abort <= 1'b1;
                                case (state)
                                    ST_START: state <= ST_ADDR;
                                    ST_ADDR:  state <= i2c_error ? ST_STOP : ST_HI;
                                    ST_HI:    state <= i2c_error ? ST_STOP : ST_LO;
                                    ST_LO:    state <= ST_STOP;
                                    default: begin
                                        // Stop finished: either retry this entry or advance to the next one.
                                        if (abort) begin
                                            abort     <= 1'b0;
                                            retry_cnt <= retry_next[1:0];
                                            if (retry_next == {1'b0, MAX_RETRY}) begin
                                                state    <= ST_FAIL;
                                                cfg_fail <= 1'b1;
                                                cfg_busy <= 1'b0;
                                            end else begin
                                                state <= ST_START;
                                            end
                                        end else begin
                                            retry_cnt <= '0;
                                            rom_addr  <= rom_addr + 4'd1;
                                            if (rom_addr + 4'd1 == NUM_REGS) begin
                                                state    <= ST_DONE;
                                                cfg_done <= 1'b1;
                                                cfg_busy <= 1'b0;
                                            end else begin
                                                state <= ST_START;
                                            end
                                        end
                                    end
                                endcase
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_i2c_config.sv
// Randomized scoreboard bench for codec_i2c_config with a behavioural i2c_master and slave.
// Expected bus events come from an entry/attempt-level reference model.
module tb_codec_i2c_config;

    localparam logic [15:0] PD = 16'd10;
    localparam logic [3:0]  NR = 4'd4;
    localparam logic [7:0]  DA = 8'h34;
    localparam logic [1:0]  MR = 2'd3;
    localparam int EV_START = 'h100;
    localparam int EV_STOP  = 'h200;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_busy, cfg_done, cfg_fail;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic        i2c_start_transaction, i2c_end_transaction, i2c_start_write, i2c_start_read;
    logic [7:0]  i2c_data_out;
    logic        m_ready = 1'b1, m_busy = 1'b0, m_error = 1'b0, m_pend_err = 1'b0;
    int          m_timer = 0, m_code = 0, m_wr_idx = 0;

    logic [15:0] rom [16];
    int          exp_q[$];
    int          slave_plan[$];
    int          run_plan[$];
    int          n_checks = 0, n_pass = 0;
    int          exp_done, exp_fail, exp_addr;
    int          lat, cyc, wcount, mon_obs, mon_nstb;
    logic        prev_strobe = 1'b0;

    assign rom_data = rom[rom_addr];

    always #5 clock = ~clock;

    codec_i2c_config #(
        .POWERUP_DELAY(PD), .NUM_REGS(NR), .DEVICE_ADDR(DA), .MAX_RETRY(MR)
    ) dut (
        .clock(clock), .reset_n(reset_n), .cfg_start(cfg_start),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_fail(cfg_fail),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .i2c_start_transaction(i2c_start_transaction), .i2c_end_transaction(i2c_end_transaction),
        .i2c_start_write(i2c_start_write), .i2c_start_read(i2c_start_read),
        .i2c_data_out(i2c_data_out),
        .i2c_ready(m_ready), .i2c_error(m_error), .i2c_busy(m_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    endtask

    // Master with no reset: random service time; the slave NACKs the write byte named by the attempt's plan code (1=addr, 2=hi, 3=lo).
    always @(posedge clock) begin
        if (i2c_start_transaction || i2c_end_transaction || i2c_start_write) begin
            m_ready <= 1'b0;
            m_busy  <= 1'b1;
            m_timer <= int'($urandom_range(2, 5));
            if (i2c_start_transaction) begin
                m_code     = (slave_plan.size() > 0) ? slave_plan.pop_front() : 0;
                m_wr_idx   = 0;
                m_pend_err <= 1'b0;
            end else if (i2c_start_write) begin
                m_wr_idx++;
                m_pend_err <= (m_wr_idx == m_code);
            end else begin
                m_pend_err <= 1'b0;
            end
        end else if (m_timer > 0) begin
            m_timer <= m_timer - 1;
            if (m_timer == 1) begin
                m_ready <= 1'b1;
                m_busy  <= 1'b0;
                m_error <= m_pend_err;
            end
        end
    end

    always @(negedge clock) begin
        mon_nstb = int'(i2c_start_transaction) + int'(i2c_end_transaction)
                 + int'(i2c_start_write) + int'(i2c_start_read);
        if (mon_nstb != 0)
            chk("protocol", int'(mon_nstb == 1 && !i2c_start_read && !prev_strobe && m_ready && !m_busy), 1);
        if (i2c_start_transaction || i2c_end_transaction || i2c_start_write) begin
            if (i2c_start_transaction)    mon_obs = EV_START;
            else if (i2c_end_transaction) mon_obs = EV_STOP;
            else                          mon_obs = int'(i2c_data_out);
            if (exp_q.size() == 0) chk("unexpected_event", mon_obs, -1);
            else                   chk("bus_event", mon_obs, exp_q.pop_front());
        end
        prev_strobe = (mon_nstb != 0);
    end

    // Reference: for each attempt emit S, addr, the bytes sent before any NACK, P; then retry or advance.
    task automatic build_expected();
        int entry, retry, idx, code;
        entry = 0; retry = 0; idx = 0;
        exp_done = 0; exp_fail = 0; exp_addr = 0;
        forever begin
            code = (idx < run_plan.size()) ? run_plan[idx] : 0;
            idx++;
            exp_q.push_back(EV_START);
            exp_q.push_back(int'(DA));
            if (code != 1) begin
                exp_q.push_back(int'(rom[entry][15:8]));
                if (code != 2) exp_q.push_back(int'(rom[entry][7:0]));
            end
            exp_q.push_back(EV_STOP);
            if (code >= 1 && code <= 3) begin
                retry++;
                if (retry == int'(MR)) begin
                    exp_fail = 1; exp_addr = entry;
                    break;
                end
            end else begin
                retry = 0;
                entry++;
                if (entry == int'(NR)) begin
                    exp_done = 1; exp_addr = entry;
                    break;
                end
            end
        end
    endtask

    // Called at a negedge; from_start=0 releases reset, 1 pulses cfg_start from DONE/FAIL.
    task automatic applyStimulus(input bit from_start, input bit mid_pulse);
        slave_plan = run_plan;
        build_expected();
        if (from_start) cfg_start = 1'b1;
        else            reset_n = 1'b1;
        lat = 0;
        do begin
            @(negedge clock);
            cfg_start = 1'b0;
            lat++;
        end while (!i2c_start_transaction && lat < 200);
        if (from_start) chk("restart_latency", lat, 2);
        else            chk("powerup_latency", lat, int'(PD) + 1);
        if (mid_pulse) begin
            repeat (20) @(negedge clock);
            cfg_start = 1'b1;
            @(negedge clock);
            cfg_start = 1'b0;
            repeat (2) @(negedge clock);
            chk("busy_after_ignored_start", int'(cfg_busy), 1);
        end
        cyc = 0;
        while (!(cfg_done || cfg_fail) && cyc < 5000) begin
            @(negedge clock);
            cyc++;
        end
        chk("run_timeout", int'(cyc < 5000), 1);
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, "_done"}, int'(cfg_done), exp_done);
        chk({tag, "_fail"}, int'(cfg_fail), exp_fail);
        chk({tag, "_busy"}, int'(cfg_busy), 0);
        chk({tag, "_rom_addr"}, int'(rom_addr), exp_addr);
        chk({tag, "_pending_events"}, exp_q.size(), 0);
    endtask

    task automatic random_plan();
        run_plan.delete();
        for (int i = 0; i < 12; i++)
            run_plan.push_back(($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3)));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h1E00;
        rom[1] = 16'h0C10;

        repeat (3) @(negedge clock);
        chk("rst_busy", int'(cfg_busy), 0);
        chk("rst_done", int'(cfg_done), 0);
        chk("rst_fail", int'(cfg_fail), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_strobes", int'({i2c_start_transaction, i2c_end_transaction, i2c_start_write, i2c_start_read}), 0);
        chk("rst_data_out", int'(i2c_data_out), 0);

        $display("[TB] basic run");
        run_plan.delete();
        applyStimulus(1'b0, 1'b0);
        checkOutput("basic");

        $display("[TB] single NACK on address with ignored mid-run start");
        run_plan.delete();
        run_plan.push_back(1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("single_nack");

        $display("[TB] persistent NACK on high byte of entry 1");
        run_plan.delete();
        run_plan.push_back(0);
        for (int i = 0; i < 3; i++) run_plan.push_back(2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("persistent_nack");

        for (int r = 0; r < 6; r++) begin
            $display("[TB] random run %0d", r);
            for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
            random_plan();
            applyStimulus(1'b1, bit'($urandom_range(0, 1)));
            checkOutput("random");
        end

        $display("[TB] reset during low byte of entry 1");
        run_plan.delete();
        slave_plan = run_plan;
        build_expected();
        cfg_start = 1'b1;
        @(negedge clock);
        cfg_start = 1'b0;
        wcount = 0;
        cyc = 0;
        while (wcount < 6 && cyc < 1000) begin
            @(negedge clock);
            if (i2c_start_write) wcount++;
            cyc++;
        end
        chk("lo_write_reached", wcount, 6);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        exp_q.delete();
        slave_plan.delete();
        @(negedge clock);
        chk("midrst_strobes", int'({i2c_start_transaction, i2c_end_transaction, i2c_start_write}), 0);
        chk("midrst_busy", int'(cfg_busy), 0);
        chk("midrst_rom_addr", int'(rom_addr), 0);
        random_plan();
        applyStimulus(1'b0, 1'b0);
        checkOutput("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
